// File: rtl/alu_dsp48_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_dsp48_core
// Purpose  : Behavioural DSP48A1 slice (A1/B1/OPMODE/M/P registered) that
//            serves as the shared responder of the flat ALU DSP bus.
// Revision : 1.0 - initial release
// ============================================================================
module alu_dsp48_core #(
  parameter int N_CLIENTS = 2,
  parameter int SEL_W     = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        dsp_sel,
  input  logic [44*N_CLIENTS-1:0] dsp_ins_all,
  output logic [83:0]             dsp_outs_flat
);

  localparam logic [1:0] c_x_zero = 2'd0;
  localparam logic [1:0] c_x_m    = 2'd1;
  localparam logic [1:0] c_x_p    = 2'd2;
  localparam logic [1:0] c_x_ab   = 2'd3;
  localparam logic [1:0] c_z_p    = 2'd2;

  logic [43:0] w_words [N_CLIENTS];
  logic [43:0] w_sel_word;

  generate
    for (genvar gi = 0; gi < N_CLIENTS; gi++) begin : g_client
      assign w_words[gi] = dsp_ins_all[44*gi +: 44];
    end
  endgenerate

  // Out-of-range selects fall back to the all-zero word so P clears.
  always_comb begin
    w_sel_word = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      if (int'(dsp_sel) == i) begin
        w_sel_word = w_words[i];
      end
    end
  end

  // Stage 1: operand and opmode registers.
  logic signed [17:0] r_a1;
  logic signed [17:0] r_b1;
  logic [7:0]         r_op1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a1  <= '0;
      r_b1  <= '0;
      r_op1 <= '0;
    end else begin
      r_a1  <= w_sel_word[35:18];
      r_b1  <= w_sel_word[17:0];
      r_op1 <= w_sel_word[43:36];
    end
  end

  // Preadder with D tied to zero: subtract mode simply negates B.
  logic signed [17:0] w_b1p;
  assign w_b1p = (r_op1[4] && r_op1[6]) ? -r_b1 : r_b1;

  // Stage 2: multiplier register plus the opmode bits still needed later.
  logic signed [35:0] r_m;
  logic [17:0]        r_a2;
  logic [17:0]        r_b2;
  logic               r_postsub2;
  logic               r_cin2;
  logic [1:0]         r_z2;
  logic [1:0]         r_x2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_m        <= '0;
      r_a2       <= '0;
      r_b2       <= '0;
      r_postsub2 <= 1'b0;
      r_cin2     <= 1'b0;
      r_z2       <= '0;
      r_x2       <= '0;
    end else begin
      r_m        <= r_a1 * w_b1p;
      r_a2       <= r_a1;
      r_b2       <= r_b1;
      r_postsub2 <= r_op1[7];
      r_cin2     <= r_op1[5];
      r_z2       <= r_op1[3:2];
      r_x2       <= r_op1[1:0];
    end
  end

  // Stage 3: X/Z muxes and the post-adder.
  logic [47:0] r_p;
  logic [47:0] w_x;
  logic [47:0] w_z;
  logic [47:0] w_xc;

  always_comb begin
    w_x = '0;
    case (r_x2)
      c_x_zero: w_x = '0;
      c_x_m:    w_x = {{12{r_m[35]}}, r_m};
      c_x_p:    w_x = r_p;
      c_x_ab:   w_x = {12'h000, r_a2, r_b2};
      default:  w_x = '0;
    endcase
  end

  // PCIN and C are not modelled, so only the P feedback is non-zero.
  assign w_z  = (r_z2 == c_z_p) ? r_p : 48'd0;
  assign w_xc = w_x + {47'd0, r_cin2};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
    end else if (r_postsub2) begin
      r_p <= w_z - w_xc;
    end else begin
      r_p <= w_z + w_xc;
    end
  end

  assign dsp_outs_flat = {r_m, r_p};

endmodule
`default_nettype wire
